// File: rtl/sysa_skew_feeder.sv
// Row-word FIFO plus diagonal-skew delay lines feeding the 3x3 systolic array; appends
// LANES-1 zero rows after the last row. Optional `define SKEW_FEEDER_STATS_EN adds row_count.
module sysa_skew_feeder #(
  parameter int LANES      = 3,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic                in_last,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [7:0]          row_count
`endif
);

  // Handshake: a word transfers on any clk edge where in_valid && in_ready are both high.
  localparam int W  = LANES * DW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (LANES > 2) ? $clog2(LANES - 1) : 1;
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LANES - 2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       drain_cnt;
  logic [W-1:0]        mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_next;
  logic                push, pop, pop_last, empty;
  logic                start_ok, feed_step, drain_step, shift_en;
  logic [W-1:0]        row;

  assign empty      = (count == '0);
  assign push       = in_valid && in_ready;
  assign feed_step  = step && (state == S_FEED);
  assign drain_step = step && (state == S_DRAIN);
  assign pop        = feed_step && !empty;
  assign pop_last   = pop && last_mem[rd_ptr];
  assign start_ok   = start && (state == S_IDLE);
  assign shift_en   = feed_step || drain_step;
  assign busy       = (state != S_IDLE);

  // Underrun and drain steps both inject a zero row.
  always_comb begin
    row = '0;
    if (pop) row = mem[rd_ptr];
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= in_data;
      last_mem[wr_ptr] <= in_last;
    end
  end

  // in_ready is registered, so a pop while full frees space only from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FEED;
            underrun <= 1'b0;
          end
        end
        S_FEED: begin
          if (step) begin
            out_valid <= 1'b1;
            if (empty) underrun <= 1'b1;
            if (pop_last) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (step) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= S_IDLE;
              done      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lane k passes through k+1 registers: k steps of skew plus the output stage.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] sr [0:k];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) sr[j] <= '0;
      end else if (start_ok) begin
        for (int j = 0; j <= k; j++) sr[j] <= '0;
      end else if (shift_en) begin
        sr[0] <= row[k*DW +: DW];
        for (int j = 1; j <= k; j++) sr[j] <= sr[j-1];
      end
    end
    assign out_data[k*DW +: DW] = sr[k];
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       row_count <= '0;
    else if (start_ok)                row_count <= '0;
    else if (pop && row_count != 8'hFF) row_count <= row_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sysa_skew_feeder.sv
// Directed bench for sysa_skew_feeder: streaming, FIFO full, underrun, reset, start-in-drain.
module tb_sysa_skew_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [23:0] out_data;
  logic        out_valid, busy, done, underrun;
`ifdef SKEW_FEEDER_STATS_EN
  logic [7:0]  row_count;
`endif
  int checks = 0;
  int errors = 0;

  sysa_skew_feeder dut (
    .clk(clk), .rst_n(rst_n), .step(step), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
    .underrun(underrun)
`ifdef SKEW_FEEDER_STATS_EN
    , .row_count(row_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [23:0] d, input logic l);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (in_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({out_data, out_valid, busy, done, underrun, in_ready} !== {24'h0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: data=%h v=%b busy=%b done=%b ur=%b rdy=%b", out_data,
               out_valid, busy, done, underrun, in_ready);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [23:0] exp [5] = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000};
    push_word(24'h030201, 1'b0);
    push_word(24'h060504, 1'b0);
    push_word(24'h090807, 1'b1);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_started: busy=%b out_valid=%b required 1/0", busy, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      do_step();
      checks++;
      if (out_data !== exp[i]) begin
        errors++;
        $display("FAIL basic_step%0d: out_data=%h required %h", i, out_data, exp[i]);
      end
      checks++;
      if (done !== (i == 4)) begin
        errors++;
        $display("FAIL basic_done%0d: done=%b required %b", i, done, (i == 4));
      end
      if (i < 4) begin
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_valid%0d: out_valid=%b busy=%b required 1/1", i, out_valid, busy);
        end
      end
`ifdef SKEW_FEEDER_STATS_EN
      if (i == 4) begin
        checks++;
        if (row_count !== 8'd3) begin
          errors++;
          $display("FAIL basic_row_count: row_count=%0d required 3", row_count);
        end
      end
`endif
      idle(3);
    end
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: done=%b v=%b busy=%b ur=%b required 0/0/0/0", done,
               out_valid, busy, underrun);
    end
  endtask

  task automatic test_fifo_full();
    logic [23:0] exp [7] = '{24'h000010, 24'h002011, 24'h302112, 24'h312213,
                             24'h322314, 24'h332400, 24'h340000};
    for (int i = 0; i < 4; i++) push_word({4'h3, 4'(i), 4'h2, 4'(i), 4'h1, 4'(i)}, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 24'h342414;
    in_last  = 1'b1;
    idle(2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: in_ready=%b required 0", in_ready);
    end
    pulse_start();
    for (int n = 0; n < 7; n++) begin
      do_step();
      if (n == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_freed: in_ready=%b required 1", in_ready);
        end
        idle(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_data !== exp[0]) begin
          errors++;
          $display("FAIL full_step0: out_data=%h required %h", out_data, exp[0]);
        end
        idle(2);
      end else begin
        checks++;
        if (out_data !== exp[n]) begin
          errors++;
          $display("FAIL full_step%0d: out_data=%h required %h", n, out_data, exp[n]);
        end
        checks++;
        if (done !== (n == 6)) begin
          errors++;
          $display("FAIL full_done%0d: done=%b required %b", n, done, (n == 6));
        end
        idle(3);
      end
    end
    checks++;
    if (busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL full_end: busy=%b underrun=%b required 0/0", busy, underrun);
    end
  endtask

  task automatic test_underrun();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      do_step();
      checks++;
      if (out_data !== 24'h0 || underrun !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL underrun_step%0d: data=%h ur=%b v=%b required 000000/1/1", i,
                 out_data, underrun, out_valid);
      end
      if (i == 1) push_word(24'h0A0A0A, 1'b1);
      else idle(3);
    end
    do_step();
    checks++;
    if (out_data !== 24'h00000A) begin
      errors++;
      $display("FAIL underrun_step2: out_data=%h required 00000a", out_data);
    end
    idle(3);
    do_step();
    checks++;
    if (out_data !== 24'h000A00 || done !== 1'b0) begin
      errors++;
      $display("FAIL underrun_step3: data=%h done=%b required 000a00/0", out_data, done);
    end
    idle(3);
    do_step();
    checks++;
    if (out_data !== 24'h0A0000 || done !== 1'b1 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_step4: data=%h done=%b ur=%b required 0a0000/1/1", out_data,
               done, underrun);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp [5] = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000};
    push_word(24'h030201, 1'b0);
    pulse_start();
    do_step();
    do_step();
    push_word(24'hFFFFFF, 1'b0);
    checks++;
    if (busy !== 1'b1 || underrun !== 1'b1 || out_data === 24'h0) begin
      errors++;
      $display("FAIL midrst_pre: busy=%b ur=%b data=%h required 1/1/nonzero", busy,
               underrun, out_data);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_data, out_valid, busy, done, underrun, in_ready} !== {24'h0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL midrst_async: data=%h v=%b busy=%b done=%b ur=%b rdy=%b", out_data,
               out_valid, busy, done, underrun, in_ready);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    push_word(24'h030201, 1'b0);
    push_word(24'h060504, 1'b0);
    push_word(24'h090807, 1'b1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      do_step();
      checks++;
      if (out_data !== exp[i] || done !== (i == 4)) begin
        errors++;
        $display("FAIL midrst_step%0d: data=%h done=%b required %h/%b", i, out_data, done,
                 exp[i], (i == 4));
      end
      idle(3);
    end
  endtask

  task automatic test_start_in_drain();
    push_word(24'h0C0B0A, 1'b0);
    push_word(24'h0F0E0D, 1'b1);
    pulse_start();
    do_step();
    checks++;
    if (out_data !== 24'h00000A) begin
      errors++;
      $display("FAIL drain_step0: out_data=%h required 00000a", out_data);
    end
    idle(3);
    do_step();
    idle(1);
    pulse_start();
    checks++;
    if (out_data !== 24'h000B0D || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_ignore: data=%h busy=%b required 000b0d/1", out_data, busy);
    end
    idle(2);
    do_step();
    checks++;
    if (out_data !== 24'h0C0E00 || done !== 1'b0) begin
      errors++;
      $display("FAIL drain_step2: data=%h done=%b required 0c0e00/0", out_data, done);
    end
    idle(3);
    do_step();
    checks++;
    if (out_data !== 24'h0F0000 || done !== 1'b1) begin
      errors++;
      $display("FAIL drain_step3: data=%h done=%b required 0f0000/1", out_data, done);
    end
    idle(3);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

`ifdef SKEW_FEEDER_STATS_EN
  task automatic test_stats_saturate();
    pulse_start();
    checks++;
    if (row_count !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear: row_count=%0d required 0", row_count);
    end
    for (int i = 0; i < 300; i++) begin
      push_word(24'(i), (i == 299));
      do_step();
    end
    do_step();
    do_step();
    checks++;
    if (row_count !== 8'd255 || done !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL stats_sat: row_count=%0d done=%b ur=%b required 255/1/0", row_count,
               done, underrun);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_underrun();
    test_reset_mid();
    test_start_in_drain();
`ifdef SKEW_FEEDER_STATS_EN
    test_stats_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
